store_buffer: RTL and testbench

- Store-side counterpart of the load FU: accepts issued SB/SH/SW ops, computes address and byte-lane data, and holds them until ROB commit.
- Drains committed stores in order to the data BRAM write port.
- Uncommitted younger stores are flushed on mispredict.
- Sits between the store reservation station, the ROB commit port and the data memory.

---
 rtl/store_buffer.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_store_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Purpose:
//   Holds issued SB/SH/SW stores between issue and ROB commit. Each store
//   gets its word-aligned address, lane-shifted data and byte strobes
//   computed at allocation. Committed stores drain in order to the data
//   BRAM write port. Uncommitted stores younger than a mispredicted branch
//   are discarded.
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   st_*                 store issue from the store RS (valid, func3, imm,
//                        rob tag) plus operands ps1_data / ps2_data
//   commit_valid/_rob_tag  ROB retirement of one tag per cycle
//   mispredict/_tag      branch flush request, curr_rob_tag = ROB tail
//   sb_full              no free entry (registered)
//   st_done/_rob_index   store captured, one cycle after issue
//   mem_we/_addr/_wdata/_wstrb, mem_ready   BRAM write handshake
//   ld_addr, fwd_hit, fwd_data              store-to-load forwarding
//
// Configuration:
//   STORE_FWD_EN  when defined, full-word store-to-load forwarding is
//                 enabled; otherwise fwd_hit / fwd_data are tied to 0.
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [2:0]       st_func3,
  input  logic [31:0]      st_imm,
  input  logic [ROB_W-1:0] st_rob_index,
  input  logic [31:0]      ps1_data,
  input  logic [31:0]      ps2_data,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob_tag,
  input  logic             mispredict,
  input  logic [ROB_W-1:0] mispredict_tag,
  input  logic [ROB_W-1:0] curr_rob_tag,
  output logic             sb_full,
  output logic             st_done,
  output logic [ROB_W-1:0] st_done_rob_index,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      ld_addr,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0] entryValid_q, entryValid_d;
  logic [DEPTH-1:0] entryCommitted_q, entryCommitted_d;
  logic [ROB_W-1:0] entryRob_q [DEPTH];
  logic [ROB_W-1:0] entryRob_d [DEPTH];
  logic [31:0]      entryAddr_q [DEPTH];
  logic [31:0]      entryAddr_d [DEPTH];
  logic [31:0]      entryData_q [DEPTH];
  logic [31:0]      entryData_d [DEPTH];
  logic [3:0]       entryStrb_q [DEPTH];
  logic [3:0]       entryStrb_d [DEPTH];

  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             sbFull_q;
  logic             stDone_q;
  logic [ROB_W-1:0] stDoneRob_q;

  logic             popHead;
  logic [DEPTH-1:0] commitHit;
  logic [DEPTH-1:0] committedEff;
  logic [DEPTH-1:0] flushHit;
  logic [PTR_W:0]   flushCount;
  logic [PTR_W-1:0] allocIdx;
  logic [PTR_W-1:0] nextHead;

  logic [31:0]      effAddr;
  logic [31:0]      allocData;
  logic [3:0]       allocStrb;
  logic             funcOk;
  logic             allocEn;

  // Tag t is younger than the branch when its distance past the branch is
  // non-zero and still short of the ROB tail; all arithmetic wraps mod 2^ROB_W.
  function automatic logic isYounger(input logic [ROB_W-1:0] tag,
                                     input logic [ROB_W-1:0] brTag,
                                     input logic [ROB_W-1:0] tailTag);
    logic [ROB_W-1:0] distTag;
    logic [ROB_W-1:0] distTail;
    distTag  = tag - brTag;
    distTail = tailTag - brTag;
    return (distTag != '0) && (distTag < distTail);
  endfunction

  // Commit is applied before the flush check, so an entry retiring in the
  // same cycle as a mispredict is treated as committed and survives.
  // Flushed entries are a contiguous tail suffix, so counting them is enough
  // to rewind the tail pointer.
  always_comb begin
    popHead    = (state_q == WRITE) && mem_ready;
    commitHit  = '0;
    committedEff = '0;
    flushHit   = '0;
    flushCount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      commitHit[i]    = commit_valid && entryValid_q[i] &&
                        (entryRob_q[i] == commit_rob_tag);
      committedEff[i] = entryCommitted_q[i] || commitHit[i];
      flushHit[i]     = mispredict && entryValid_q[i] && !committedEff[i] &&
                        isYounger(entryRob_q[i], mispredict_tag, curr_rob_tag);
      flushCount      = flushCount + {{PTR_W{1'b0}}, flushHit[i]};
    end
  end

  // Byte-lane placement of the incoming store; unsupported func3 codes
  // leave funcOk low so the op is silently dropped.
  always_comb begin
    effAddr   = ps1_data + st_imm;
    allocData = '0;
    allocStrb = '0;
    funcOk    = 1'b0;
    case (st_func3)
      3'b000: begin
        funcOk    = 1'b1;
        allocStrb = 4'b0001 << effAddr[1:0];
        allocData = {24'b0, ps2_data[7:0]} << {effAddr[1:0], 3'b000};
      end
      3'b001: begin
        funcOk    = 1'b1;
        allocStrb = effAddr[1] ? 4'b1100 : 4'b0011;
        allocData = effAddr[1] ? {ps2_data[15:0], 16'b0} : {16'b0, ps2_data[15:0]};
      end
      3'b010: begin
        funcOk    = 1'b1;
        allocStrb = 4'b1111;
        allocData = ps2_data;
      end
      default: begin
        funcOk    = 1'b0;
      end
    endcase
  end

  // Fullness is judged on the pre-edge count, so a same-cycle pop never
  // opens a slot for a store issued while full.
  always_comb begin
    allocEn  = st_valid && (count_q != FULL_COUNT) && funcOk &&
               !(mispredict && isYounger(st_rob_index, mispredict_tag, curr_rob_tag));
    allocIdx = tailPtr_q - flushCount[PTR_W-1:0];
    nextHead = headPtr_q + PTR_W'(1);
  end

  // Next contents of the entry array: commit marks, flush clears, head pop,
  // then the new allocation at the rewound tail.
  always_comb begin
    entryValid_d     = entryValid_q & ~flushHit;
    entryCommitted_d = entryCommitted_q | commitHit;
    entryRob_d       = entryRob_q;
    entryAddr_d      = entryAddr_q;
    entryData_d      = entryData_q;
    entryStrb_d      = entryStrb_q;
    if (popHead) begin
      entryValid_d[headPtr_q]     = 1'b0;
      entryCommitted_d[headPtr_q] = 1'b0;
    end
    if (allocEn) begin
      entryValid_d[allocIdx]     = 1'b1;
      entryCommitted_d[allocIdx] = 1'b0;
      entryRob_d[allocIdx]       = st_rob_index;
      entryAddr_d[allocIdx]      = {effAddr[31:2], 2'b00};
      entryData_d[allocIdx]      = allocData;
      entryStrb_d[allocIdx]      = allocStrb;
    end
  end

  always_comb begin
    headPtr_d = popHead ? nextHead : headPtr_q;
    tailPtr_d = allocIdx + PTR_W'(allocEn);
    count_d   = count_q - flushCount - (PTR_W+1)'(popHead) + (PTR_W+1)'(allocEn);
  end

  // Storage, pointers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      entryValid_q     <= '0;
      entryCommitted_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryRob_q[i]  <= '0;
        entryAddr_q[i] <= '0;
        entryData_q[i] <= '0;
        entryStrb_q[i] <= '0;
      end
      headPtr_q   <= '0;
      tailPtr_q   <= '0;
      count_q     <= '0;
      sbFull_q    <= 1'b0;
      stDone_q    <= 1'b0;
      stDoneRob_q <= '0;
    end else begin
      entryValid_q     <= entryValid_d;
      entryCommitted_q <= entryCommitted_d;
      entryRob_q       <= entryRob_d;
      entryAddr_q      <= entryAddr_d;
      entryData_q      <= entryData_d;
      entryStrb_q      <= entryStrb_d;
      headPtr_q   <= headPtr_d;
      tailPtr_q   <= tailPtr_d;
      count_q     <= count_d;
      sbFull_q    <= (count_d == FULL_COUNT);
      stDone_q    <= allocEn;
      stDoneRob_q <= allocEn ? st_rob_index : '0;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM next state; a commit arriving this cycle already counts, so
  // the write starts on the commit edge and back-to-back commits stream.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (entryValid_q[headPtr_q] && committedEff[headPtr_q]) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          state_d = (entryValid_q[nextHead] && committedEff[nextHead]) ? WRITE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain FSM outputs: the head entry is presented while in WRITE and the
  // head only moves on the accepting edge, so the request stays stable.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state_q == WRITE) begin
      mem_we    = 1'b1;
      mem_addr  = entryAddr_q[headPtr_q];
      mem_wdata = entryData_q[headPtr_q];
      mem_wstrb = entryStrb_q[headPtr_q];
    end
  end

  assign sb_full           = sbFull_q;
  assign st_done           = stDone_q;
  assign st_done_rob_index = stDoneRob_q;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] fwdIdx;
  logic             unused_ld_addr_lsb;

  assign unused_ld_addr_lsb = ^ld_addr[1:0];

  // Walk from oldest to youngest so the last match, the youngest, wins.
  // Only full-word stores can forward; partial overlaps miss.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwdIdx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwdIdx = headPtr_q + PTR_W'(k);
      if (entryValid_q[fwdIdx] && (entryAddr_q[fwdIdx] == {ld_addr[31:2], 2'b00}) &&
          (entryStrb_q[fwdIdx] == 4'b1111)) begin
        fwd_hit  = 1'b1;
        fwd_data = entryData_q[fwdIdx];
      end
    end
  end
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Purpose:
//   Self-checking bench for store_buffer: a table of single-store vectors
//   (issue, commit, drain) followed by hand-written sequences for flush,
//   full, stall, streaming, reset and forwarding behaviour.
//   STORE_FWD_EN selects which forwarding expectations apply.
// ---------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int ROB_W = 5;

  logic             clk;
  logic             reset;
  logic             st_valid;
  logic [2:0]       st_func3;
  logic [31:0]      st_imm;
  logic [ROB_W-1:0] st_rob_index;
  logic [31:0]      ps1_data;
  logic [31:0]      ps2_data;
  logic             commit_valid;
  logic [ROB_W-1:0] commit_rob_tag;
  logic             mispredict;
  logic [ROB_W-1:0] mispredict_tag;
  logic [ROB_W-1:0] curr_rob_tag;
  logic             sb_full;
  logic             st_done;
  logic [ROB_W-1:0] st_done_rob_index;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_ready;
  logic [31:0]      ld_addr;
  logic             fwd_hit;
  logic [31:0]      fwd_data;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [2:0]  func3;
    logic [31:0] ps1;
    logic [31:0] imm;
    logic [31:0] ps2;
    logic [4:0]  rob;
    logic        expDone;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [3:0]  expStrb;
  } vec_t;

  vec_t vecs [11];

  store_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .st_valid          (st_valid),
    .st_func3          (st_func3),
    .st_imm            (st_imm),
    .st_rob_index      (st_rob_index),
    .ps1_data          (ps1_data),
    .ps2_data          (ps2_data),
    .commit_valid      (commit_valid),
    .commit_rob_tag    (commit_rob_tag),
    .mispredict        (mispredict),
    .mispredict_tag    (mispredict_tag),
    .curr_rob_tag      (curr_rob_tag),
    .sb_full           (sb_full),
    .st_done           (st_done),
    .st_done_rob_index (st_done_rob_index),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .mem_ready         (mem_ready),
    .ld_addr           (ld_addr),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    st_valid     = 1'b1;
    st_func3     = v.func3;
    ps1_data     = v.ps1;
    st_imm       = v.imm;
    ps2_data     = v.ps2;
    st_rob_index = v.rob;
  endtask

  // Issue one SW at an absolute address for one cycle.
  task automatic issueSw(input logic [4:0] rob, input logic [31:0] addr,
                         input logic [31:0] data);
    st_valid     = 1'b1;
    st_func3     = 3'b010;
    ps1_data     = addr;
    st_imm       = 32'h0;
    ps2_data     = data;
    st_rob_index = rob;
    tick();
    st_valid     = 1'b0;
  endtask

  task automatic commitTag(input logic [4:0] rob);
    commit_valid   = 1'b1;
    commit_rob_tag = rob;
  endtask

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    reset          = 1'b0;
    st_valid       = 1'b0;
    st_func3       = 3'b000;
    st_imm         = 32'h0;
    st_rob_index   = '0;
    ps1_data       = 32'h0;
    ps2_data       = 32'h0;
    commit_valid   = 1'b0;
    commit_rob_tag = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
    curr_rob_tag   = '0;
    mem_ready      = 1'b0;
    ld_addr        = 32'h0;

    //          func3   ps1           imm           ps2           rob done addr          data          strb
    vecs[0]  = '{3'b010, 32'h0,       32'h0,        32'hDEADBEEF, 5'd1,  1'b1, 32'h0,    32'hDEADBEEF, 4'b1111};
    vecs[1]  = '{3'b000, 32'h4,       32'h1,        32'h123456AB, 5'd2,  1'b1, 32'h4,    32'h0000AB00, 4'b0010};
    vecs[2]  = '{3'b001, 32'h10,      32'hFFFFFFF6, 32'hFFFF1234, 5'd3,  1'b1, 32'h4,    32'h12340000, 4'b1100};
    vecs[3]  = '{3'b001, 32'h100,     32'h1,        32'h0000BEEF, 5'd4,  1'b1, 32'h100,  32'h0000BEEF, 4'b0011};
    vecs[4]  = '{3'b000, 32'h200,     32'h3,        32'h0000005A, 5'd5,  1'b1, 32'h200,  32'h5A000000, 4'b1000};
    vecs[5]  = '{3'b000, 32'h1000,    32'h0,        32'h0000FF77, 5'd6,  1'b1, 32'h1000, 32'h00000077, 4'b0001};
    vecs[6]  = '{3'b010, 32'h20,      32'hF,        32'hCAFEF00D, 5'd7,  1'b1, 32'h2C,   32'hCAFEF00D, 4'b1111};
    vecs[7]  = '{3'b011, 32'h40,      32'h0,        32'h11111111, 5'd8,  1'b0, 32'h0,    32'h0,        4'b0000};
    vecs[8]  = '{3'b100, 32'h44,      32'h0,        32'h22222222, 5'd9,  1'b0, 32'h0,    32'h0,        4'b0000};
    vecs[9]  = '{3'b010, 32'hFFFFFFFC, 32'h8,       32'h01020304, 5'd10, 1'b1, 32'h4,    32'h01020304, 4'b1111};
    vecs[10] = '{3'b001, 32'h2,       32'h0,        32'h0000A5A5, 5'd11, 1'b1, 32'h0,    32'hA5A50000, 4'b1100};

    // Reset state.
    tick();
    tick();
    checkOutput("rst_sb_full", 32'(sb_full), 32'h0);
    checkOutput("rst_st_done", 32'(st_done), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_fwd_hit", 32'(fwd_hit), 32'h0);
    reset = 1'b1;
    tick();

    // Table: issue, commit with BRAM busy, then accept.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      tick();
      st_valid = 1'b0;
      checkOutput($sformatf("vec%0d_st_done", i), 32'(st_done), 32'(vecs[i].expDone));
      if (vecs[i].expDone)
        checkOutput($sformatf("vec%0d_done_rob", i), 32'(st_done_rob_index), 32'(vecs[i].rob));
      commitTag(vecs[i].rob);
      mem_ready = 1'b0;
      tick();
      commit_valid = 1'b0;
      checkOutput($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].expDone));
      if (vecs[i].expDone) begin
        checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].expAddr);
        checkOutput($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].expData);
        checkOutput($sformatf("vec%0d_mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].expStrb));
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      checkOutput($sformatf("vec%0d_drained", i), 32'(mem_we), 32'h0);
    end

    // Flush of three uncommitted younger stores, plus a younger store
    // issued in the mispredict cycle that must not be captured.
    issueSw(5'd4, 32'h400, 32'h44444444);
    issueSw(5'd5, 32'h500, 32'h55555555);
    issueSw(5'd6, 32'h600, 32'h66666666);
    mispredict     = 1'b1;
    mispredict_tag = 5'd3;
    curr_rob_tag   = 5'd8;
    st_valid       = 1'b1;
    st_func3       = 3'b010;
    ps1_data       = 32'h700;
    st_rob_index   = 5'd7;
    tick();
    mispredict = 1'b0;
    st_valid   = 1'b0;
    checkOutput("flush_young_issue_no_done", 32'(st_done), 32'h0);
    commitTag(5'd4);
    tick();
    commit_valid = 1'b0;
    checkOutput("flush_no_write", 32'(mem_we), 32'h0);

    // Committed store drains while the rest flush; a commit in the same
    // cycle as the mispredict protects its entry.
    issueSw(5'd2, 32'h200, 32'h22220000);
    issueSw(5'd4, 32'h400, 32'h44440000);
    issueSw(5'd5, 32'h500, 32'h55550000);
    commitTag(5'd2);
    tick();
    checkOutput("mix_we_head", 32'(mem_we), 32'h1);
    checkOutput("mix_addr_head", mem_addr, 32'h200);
    commitTag(5'd4);
    mispredict = 1'b1;
    tick();
    commit_valid = 1'b0;
    mispredict   = 1'b0;
    checkOutput("mix_addr_hold", mem_addr, 32'h200);
    mem_ready = 1'b1;
    tick();
    checkOutput("mix_we_second", 32'(mem_we), 32'h1);
    checkOutput("mix_addr_second", mem_addr, 32'h400);
    checkOutput("mix_wdata_second", mem_wdata, 32'h44440000);
    tick();
    mem_ready = 1'b0;
    checkOutput("mix_idle", 32'(mem_we), 32'h0);
    commitTag(5'd5);
    tick();
    commit_valid = 1'b0;
    checkOutput("mix_flushed_no_write", 32'(mem_we), 32'h0);

    // Fill to full; the preceding flushes must have left the buffer empty.
    for (int k = 0; k < DEPTH; k++) begin
      issueSw(5'(10 + k), 32'(32'hA00 + 32'h100 * k), 32'(32'h10000000 + k));
      checkOutput($sformatf("fill%0d_sb_full", k), 32'(sb_full), (k == DEPTH - 1) ? 32'h1 : 32'h0);
    end
    issueSw(5'd14, 32'hE00, 32'hEEEEEEEE);
    checkOutput("full_drop_no_done", 32'(st_done), 32'h0);
    checkOutput("full_still_full", 32'(sb_full), 32'h1);
    commitTag(5'd10);
    mem_ready = 1'b1;
    tick();
    commit_valid = 1'b0;
    checkOutput("full_commit_we", 32'(mem_we), 32'h1);
    checkOutput("full_commit_addr", mem_addr, 32'hA00);
    checkOutput("full_before_pop", 32'(sb_full), 32'h1);
    tick();
    checkOutput("full_after_pop", 32'(sb_full), 32'h0);
    checkOutput("full_after_pop_idle", 32'(mem_we), 32'h0);
    commitTag(5'd14);
    tick();
    commit_valid = 1'b0;
    checkOutput("dropped_store_absent", 32'(mem_we), 32'h0);

    // Stall: BRAM busy for three cycles, request must hold.
    mem_ready = 1'b0;
    commitTag(5'd11);
    tick();
    commit_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("stall%0d_we", k), 32'(mem_we), 32'h1);
      checkOutput($sformatf("stall%0d_addr", k), mem_addr, 32'hB00);
      checkOutput($sformatf("stall%0d_wdata", k), mem_wdata, 32'h10000001);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    checkOutput("stall_released", 32'(mem_we), 32'h0);

    // Streaming: back-to-back commits drain one store per cycle.
    commitTag(5'd12);
    tick();
    checkOutput("stream_first_addr", mem_addr, 32'hC00);
    commitTag(5'd13);
    tick();
    commit_valid = 1'b0;
    checkOutput("stream_second_we", 32'(mem_we), 32'h1);
    checkOutput("stream_second_addr", mem_addr, 32'hD00);
    tick();
    mem_ready = 1'b0;
    checkOutput("stream_done", 32'(mem_we), 32'h0);

    // Reset in the middle of a write, with an issue in the same cycle.
    issueSw(5'd20, 32'h1400, 32'h20202020);
    commitTag(5'd20);
    tick();
    commit_valid = 1'b0;
    checkOutput("rstw_we_before", 32'(mem_we), 32'h1);
    reset        = 1'b0;
    st_valid     = 1'b1;
    st_rob_index = 5'd21;
    tick();
    st_valid = 1'b0;
    reset    = 1'b1;
    checkOutput("rstw_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rstw_sb_full", 32'(sb_full), 32'h0);
    checkOutput("rstw_st_done", 32'(st_done), 32'h0);
    commitTag(5'd20);
    mem_ready = 1'b1;
    tick();
    commit_valid = 1'b0;
    mem_ready    = 1'b0;
    checkOutput("rstw_entry_gone", 32'(mem_we), 32'h0);

    // Forwarding lookups against pending, uncommitted stores.
    issueSw(5'd1, 32'h8, 32'h11223344);
    issueSw(5'd2, 32'h8, 32'h55667788);
    st_valid     = 1'b1;
    st_func3     = 3'b000;
    ps1_data     = 32'hC;
    ps2_data     = 32'h99;
    st_rob_index = 5'd3;
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h9;
    #1;
`ifdef STORE_FWD_EN
    checkOutput("fwd_youngest_hit", 32'(fwd_hit), 32'h1);
    checkOutput("fwd_youngest_data", fwd_data, 32'h55667788);
    ld_addr = 32'hC;
    #1;
    checkOutput("fwd_partial_miss", 32'(fwd_hit), 32'h0);
    ld_addr = 32'h10;
    #1;
    checkOutput("fwd_no_entry_miss", 32'(fwd_hit), 32'h0);
`else
    checkOutput("fwd_off_hit", 32'(fwd_hit), 32'h0);
    checkOutput("fwd_off_data", fwd_data, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
